// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master family: controller states and SPI mode codes.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every (div+1) clk cycles while enabled.
module spi_clk_div #(
  parameter int DIV_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] div,
  output logic                tick
);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;

  // Tick on terminal count; counter reloads on tick and is held clear while disabled.
  always_comb begin
    tick  = enable && (cnt_q == div);
    cnt_d = cnt_q + 1'b1;
    if (!enable || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master: configurable width, divider, CPOL/CPHA, bit order and chip selects.
module spi_master_duplex
  import spi_pkg::*;
#(
  parameter  int BITS     = 8,
  parameter  int CS_COUNT = 1,
  parameter  int DIV_BITS = 4,
  localparam int SELW     = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [BITS-1:0]     tx_data,
  input  logic [SELW-1:0]     cs_sel,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                lsb_first,
  input  logic [DIV_BITS-1:0] div,
  input  logic                miso,
  output logic                sck,
  output logic                mosi,
  output logic [CS_COUNT-1:0] cs_n,
  output logic [BITS-1:0]     rx_data,
  output logic                rx_valid,
  output logic                busy
);

  localparam int               CNT_W     = $clog2(BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * BITS - 1);

  spi_state_e          state_q, state_d;
  logic [BITS-1:0]     tx_sh_q, tx_sh_d;
  logic [BITS-1:0]     rx_sh_q, rx_sh_d;
  logic [BITS-1:0]     rx_data_q, rx_data_d;
  logic [CNT_W-1:0]    edge_q, edge_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                rx_valid_q, rx_valid_d;
  logic [CS_COUNT-1:0] cs_n_q, cs_n_d;
  logic                tick;
  logic                accept;
  logic                leading;
  logic [BITS-1:0]     tx_rev;
  logic [BITS-1:0]     rx_rev;

  spi_clk_div #(
    .DIV_BITS(DIV_BITS)
  ) u_clk_div (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (state_q != ST_IDLE),
    .div    (div_q),
    .tick   (tick)
  );

  // The shifters always run MSB-first; LSB-first words are bit-reversed on the way in and out.
  assign tx_rev = {<<{tx_data}};
  assign rx_rev = {<<{rx_sh_q}};

  assign start_ready = (state_q == ST_IDLE) && reset_n;
  assign sck         = sck_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;

  // Next-state logic for the transfer sequencer and all registered outputs.
  always_comb begin
    accept     = start_valid && start_ready;
    leading    = ~edge_q[0];
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    edge_d     = edge_q;
    div_d      = div_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    cs_n_d     = cs_n_q;

    case (state_q)
      ST_IDLE: begin
        sck_d = cpol;
        if (accept) begin
          state_d = ST_LEAD;
          tx_sh_d = lsb_first ? tx_rev : tx_data;
          rx_sh_d = '0;
          edge_d  = '0;
          div_d   = div;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          mosi_d  = lsb_first ? tx_data[0] : tx_data[BITS-1];
          busy_d  = 1'b1;
          for (int unsigned i = 0; i < CS_COUNT; i++) begin
            cs_n_d[i] = (cs_sel != SELW'(i));
          end
        end
      end

      ST_LEAD: begin
        if (tick) state_d = ST_XFER;
      end

      ST_XFER: begin
        if (tick) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + 1'b1;
          if (leading) begin
            if (cpha_q) begin
              // first leading edge re-drives the bit already on mosi
              mosi_d  = tx_sh_q[BITS-1];
              tx_sh_d = tx_sh_q << 1;
            end else begin
              rx_sh_d = {rx_sh_q[BITS-2:0], miso};
            end
          end else begin
            if (cpha_q) begin
              rx_sh_d = {rx_sh_q[BITS-2:0], miso};
            end else if (edge_q != LAST_EDGE) begin
              mosi_d  = tx_sh_q[BITS-2];
              tx_sh_d = tx_sh_q << 1;
            end
          end
          if (edge_q == LAST_EDGE) begin
            state_d = ST_TRAIL;
            edge_d  = '0;
          end
        end
      end

      ST_TRAIL: begin
        if (tick) begin
          state_d    = ST_IDLE;
          cs_n_d     = '1;
          mosi_d     = 1'b1;
          busy_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = lsb_q ? rx_rev : rx_sh_q;
          sck_d      = cpol;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      edge_q     <= '0;
      div_q      <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      edge_q     <= edge_d;
      div_q      <= div_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      cs_n_q     <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_spi_master_duplex.sv
// Bench for spi_master_duplex: behavioural SPI slave on the main instance plus directed and random transfers.
module tb_spi_master_duplex;

  localparam int BITS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start_valid, cpol, cpha, lsb_first, miso;
  logic [7:0] tx_data;
  logic [1:0] cs_sel;
  logic [3:0] div;
  logic       start_ready, sck, mosi, busy, rx_valid;
  logic [3:0] cs_n;
  logic [7:0] rx_data;

  logic       start_valid3;
  logic [1:0] cs_sel3;
  logic       start_ready3, sck3, mosi3, busy3, rx_valid3;
  logic [2:0] cs_n3;
  logic [7:0] rx_data3;

  int errors = 0;
  int checks = 0;

  spi_master_duplex #(.BITS(8), .CS_COUNT(4), .DIV_BITS(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
    .tx_data(tx_data), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .div(div), .miso(miso), .sck(sck), .mosi(mosi), .cs_n(cs_n), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy)
  );

  spi_master_duplex #(.BITS(8), .CS_COUNT(3), .DIV_BITS(4)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start_valid(start_valid3), .start_ready(start_ready3),
    .tx_data(tx_data), .cs_sel(cs_sel3), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .div(div), .miso(miso), .sck(sck3), .mosi(mosi3), .cs_n(cs_n3), .rx_data(rx_data3),
    .rx_valid(rx_valid3), .busy(busy3)
  );

  // Pending command seen by the slave model, copied when the master goes busy.
  logic       p_cpol, p_cpha, p_lsb;
  logic [7:0] p_word;
  logic       a_cpol, a_cpha, a_lsb;
  logic [7:0] a_word, sl_got, tmp;
  logic       sl_prev_busy = 1'b0, sl_prev_sck = 1'b0;
  int         n_out, n_in;
  int         st_busy, st_cs_low, st_edges;
  logic [3:0] st_cs_seen;

  function automatic int pos(input int i, input logic l);
    return l ? i : BITS - 1 - i;
  endfunction

  // Behavioural SPI slave: shifts out its word and captures mosi per CPOL/CPHA, and logs frame stats.
  always @(negedge clk) begin
    if (busy === 1'b1 && !sl_prev_busy) begin
      a_cpol = p_cpol; a_cpha = p_cpha; a_lsb = p_lsb; a_word = p_word;
      n_out = 0; n_in = 0; sl_got = '0;
      st_busy = 1; st_edges = 0; st_cs_seen = cs_n;
      st_cs_low = (cs_n != 4'hF) ? 1 : 0;
      if (!a_cpha) begin
        tmp = a_word >> pos(n_out, a_lsb); miso = tmp[0]; n_out++;
      end
    end else if (busy === 1'b1) begin
      st_busy++;
      if (cs_n != 4'hF) st_cs_low++;
      if (sck != sl_prev_sck) begin
        st_edges++;
        if ((sck != a_cpol) != a_cpha) begin
          if (n_in < BITS) sl_got = sl_got | (8'(mosi) << pos(n_in, a_lsb));
          n_in++;
        end else if (n_out < BITS) begin
          tmp = a_word >> pos(n_out, a_lsb); miso = tmp[0]; n_out++;
        end
      end
    end else begin
      miso = 1'b1;
    end
    sl_prev_busy = (busy === 1'b1);
    sl_prev_sck  = sck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cs_pat(input int sel);
    return 4'hF & ~(4'h1 << (sel % 4));
  endfunction

  // Issue one command, then scramble the live inputs to prove they were latched.
  task automatic send(input logic [7:0] t, input int sel, input logic pol, input logic pha,
                      input logic lsb, input logic [3:0] d, input logic [7:0] w);
    @(negedge clk);
    tx_data = t; cs_sel = 2'(sel); cpol = pol; cpha = pha; lsb_first = lsb; div = d;
    p_cpol = pol; p_cpha = pha; p_lsb = lsb; p_word = w;
    chk("ready_idle", 32'(start_ready), 32'(1));
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    tx_data = 8'($urandom); div = 4'($urandom); cpol = 1'($urandom);
    cpha = 1'($urandom); lsb_first = 1'($urandom); cs_sel = 2'($urandom);
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input logic [7:0] t, input logic [7:0] w, input logic [3:0] d,
                           input logic [3:0] ecs);
    int n = 0;
    @(negedge clk);
    while (rx_valid !== 1'b1 && n < 1000) begin
      @(negedge clk); n++;
    end
    chk("done_in_time", 32'(n < 1000), 32'(1));
    if (n < 1000) begin
      chk("rx_data", 32'(rx_data), 32'(w));
      chk("mosi_word", 32'(sl_got), 32'(t));
      chk("ready_at_rxv", 32'(start_ready), 32'(1));
      chk("busy_end", 32'(busy), 32'(0));
      chk("cs_n_end", 32'(cs_n), 32'(4'hF));
      chk("mosi_idle", 32'(mosi), 32'(1));
      chk("sck_idle", 32'(sck), 32'(cpol));
      chk("busy_cycles", 32'(st_busy), 32'((2 * BITS + 2) * (int'(d) + 1)));
      chk("cs_low_cycles", 32'(st_cs_low), 32'((2 * BITS + 2) * (int'(d) + 1)));
      chk("cs_pattern", 32'(st_cs_seen), 32'(ecs));
      chk("sck_edges", 32'(st_edges), 32'(2 * BITS));
    end
  endtask

  task automatic do_xfer(input logic [7:0] t, input int sel, input logic pol, input logic pha,
                         input logic lsb, input logic [3:0] d, input logic [7:0] w);
    send(t, sel, pol, pha, lsb, d, w);
    wait_done(t, w, d, cs_pat(sel));
    @(negedge clk);
    chk("rx_valid_pulse", 32'(rx_valid), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad, bc, pulses;
    reset_n = 1'b0; start_valid = 1'b0; start_valid3 = 1'b0;
    tx_data = '0; cs_sel = '0; cs_sel3 = '0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = '0;
    p_cpol = 1'b0; p_cpha = 1'b0; p_lsb = 1'b0; p_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(sck), 32'(0));
    chk("rst_mosi", 32'(mosi), 32'(1));
    chk("rst_cs_n", 32'(cs_n), 32'(4'hF));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_ready", 32'(start_ready), 32'(0));
    chk("rst_cs_n3", 32'(cs_n3), 32'(3'b111));
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(start_ready), 32'(1));

    // Mode 0, msb-first, fastest divider, slave echoes the same word.
    do_xfer(8'hA5, 0, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5);
    // Mode 3, div=3, slave returns all ones.
    do_xfer(8'h3C, 0, 1'b1, 1'b1, 1'b0, 4'd3, 8'hFF);
    // Mode 1, lsb-first.
    do_xfer(8'h01, 1, 1'b0, 1'b1, 1'b1, 4'd0, 8'h80);
    // Mode 2, lsb-first, on cs 3.
    do_xfer(8'hC6, 3, 1'b1, 1'b0, 1'b1, 4'd1, 8'h2B);

    // Back-to-back: cs_sel 2 then 5 (truncated to 1), second command pending throughout.
    send(8'h5E, 2, 1'b0, 1'b0, 1'b0, 4'd1, 8'h93);
    tx_data = 8'hB1; cs_sel = 2'(5); cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0; div = 4'd0;
    p_cpol = 1'b0; p_cpha = 1'b1; p_lsb = 1'b0; p_word = 8'h4D;
    start_valid = 1'b1;
    wait_done(8'h5E, 8'h93, 4'd1, 4'b1011);
    @(negedge clk);
    chk("b2b_cs_n", 32'(cs_n), 32'(4'b1101));
    chk("b2b_busy", 32'(busy), 32'(1));
    chk("b2b_rxv_low", 32'(rx_valid), 32'(0));
    #1 start_valid = 1'b0;
    wait_done(8'hB1, 8'h4D, 4'd0, 4'b1101);
    @(negedge clk);
    chk("rx_valid_pulse", 32'(rx_valid), 32'(0));

    // Reset in the middle of a word.
    send(8'h96, 0, 1'b0, 1'b0, 1'b0, 4'd1, 8'h5A);
    n = 0;
    while (n_in < 4 && n < 500) begin
      @(negedge clk); n++;
    end
    chk("reached_bit4", 32'(n < 500), 32'(1));
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", 32'(cs_n), 32'(4'hF));
    chk("abort_mosi", 32'(mosi), 32'(1));
    chk("abort_sck", 32'(sck), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_rx_data", 32'(rx_data), 32'(0));
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) pulses++;
    end
    chk("abort_no_rxv", 32'(pulses), 32'(0));
    do_xfer(8'h69, 2, 1'b0, 1'b0, 1'b0, 4'd0, 8'hE7);

    // Out-of-range select on the three-select instance.
    @(negedge clk);
    tx_data = 8'hC3; cs_sel3 = 2'd3; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = 4'd1;
    chk("ready3", 32'(start_ready3), 32'(1));
    start_valid3 = 1'b1;
    @(posedge clk); #1;
    start_valid3 = 1'b0;
    n = 0; bad = 0; bc = 0;
    @(negedge clk);
    while (rx_valid3 !== 1'b1 && n < 500) begin
      if (cs_n3 !== 3'b111) bad++;
      if (busy3 === 1'b1) bc++;
      @(negedge clk); n++;
    end
    chk("oor_done", 32'(n < 500), 32'(1));
    chk("oor_cs_high", 32'(bad), 32'(0));
    chk("oor_busy_cycles", 32'(bc), 32'(36));
    chk("oor_rx_data", 32'(rx_data3), 32'(8'hFF));

    // Randomised transfers.
    for (int k = 0; k < 12; k++) begin
      do_xfer(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
              1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
